// File: rtl/adc_dual_capture_if.sv
// Pin and result bundle for adc_dual_capture. The capture block takes the
// master side: it drives the serial clock, the amplifier and ADC control
// pins, and the captured results. The environment takes the slave side.
interface adc_dual_capture_if #(
  parameter int DATA_W = 14,
  parameter int GAIN_W = 8
);
  logic              enable;
  logic              gain_req;
  logic [GAIN_W-1:0] gain_word;
  logic              spi_sck;
  logic              spi_mosi;
  logic              amp_cs;
  logic              amp_dout;
  logic              ad_conv;
  logic              adc_dout;
  logic [DATA_W-1:0] ch_a;
  logic [DATA_W-1:0] ch_b;
  logic              sample_valid;
  logic [GAIN_W-1:0] gain_echo;
  logic              busy;

  modport master (
    input  enable, gain_req, gain_word, amp_dout, adc_dout,
    output spi_sck, spi_mosi, amp_cs, ad_conv, ch_a, ch_b, sample_valid,
           gain_echo, busy
  );

  modport slave (
    output enable, gain_req, gain_word, amp_dout, adc_dout,
    input  spi_sck, spi_mosi, amp_cs, ad_conv, ch_a, ch_b, sample_valid,
           gain_echo, busy
  );
endinterface

// File: rtl/adc_dual_capture.sv
// Dual-channel ADC front end sequencer: loads the programmable amplifier
// gain over SPI, then runs continuous convert/read frames, capturing two
// DATA_W-bit two's complement samples per frame.
module adc_dual_capture #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 14,
  parameter int GAIN_W  = 8,
  parameter int GAP     = 0
) (
  input  logic               clk,
  input  logic               rst,
  adc_dual_capture_if.master bus
);
  localparam int READ_PULSES = 2 * DATA_W + 6;
  // GAP_TICKS only matters when GAP > 0; 1 keeps the constant legal otherwise.
  localparam int GAP_TICKS   = (GAP > 0) ? 2 * GAP : 1;
  localparam int BIT_W       = $clog2(READ_PULSES + GAIN_W + GAP_TICKS + 2);

  localparam logic [7:0]       DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] ONE       = BIT_W'(1);
  localparam logic [BIT_W-1:0] GAIN_LAST = BIT_W'(GAIN_W);
  localparam logic [BIT_W-1:0] READ_LAST = BIT_W'(READ_PULSES);
  localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'(GAP_TICKS - 1);
  localparam logic [BIT_W-1:0] A_FIRST   = BIT_W'(2);
  localparam logic [BIT_W-1:0] A_LAST    = BIT_W'(DATA_W + 1);
  localparam logic [BIT_W-1:0] B_FIRST   = BIT_W'(DATA_W + 4);
  localparam logic [BIT_W-1:0] B_LAST    = BIT_W'(2 * DATA_W + 3);

  typedef enum logic [2:0] {
    ST_IDLE, ST_GAIN_SHIFT, ST_GAIN_END, ST_CONV, ST_READ, ST_GAP
  } state_t;

  state_t            state_q;
  logic [7:0]        cnt_q;
  logic [BIT_W-1:0]  bit_q;
  logic              sck_q, mosi_q, cs_q, conv_q, busy_q, valid_q, pend_q;
  logic [DATA_W-1:0] cha_q, chb_q, sa_q, sb_q;
  logic [GAIN_W-1:0] echo_q, gain_q, gsh_q;

  logic              tick_s, pend_s, read_done_s, gap_done_s, launch_s;
  logic [GAIN_W-1:0] word_s;

  // A half-period boundary is the last clk of each divider count.
  assign tick_s      = (state_q != ST_IDLE) && (cnt_q == DIV_LAST);
  // A request arriving on the launch cycle itself is honoured immediately.
  assign pend_s      = pend_q | bus.gain_req;
  assign word_s      = bus.gain_req ? bus.gain_word : gain_q;
  assign read_done_s = (state_q == ST_READ) && tick_s && sck_q && (bit_q == READ_LAST);
  assign gap_done_s  = (state_q == ST_GAP) && tick_s && (bit_q == GAP_LAST);
  // Launch points pick the next activity: gain load, conversion, or idle.
  assign launch_s    = (state_q == ST_IDLE) || gap_done_s || (read_done_s && (GAP == 0));

  // SCK half-period divider: held at zero in IDLE, reloads at every boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if ((state_q == ST_IDLE) || tick_s) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Sequencer: state, SPI pins, capture shift registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bit_q   <= {BIT_W{1'b0}};
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      conv_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      cha_q   <= {DATA_W{1'b0}};
      chb_q   <= {DATA_W{1'b0}};
      sa_q    <= {DATA_W{1'b0}};
      sb_q    <= {DATA_W{1'b0}};
      echo_q  <= {GAIN_W{1'b1}};
      gain_q  <= {GAIN_W{1'b0}};
      gsh_q   <= {GAIN_W{1'b0}};
    end else begin
      valid_q <= 1'b0;
      if (bus.gain_req) begin
        gain_q <= bus.gain_word;
        pend_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          sck_q <= 1'b0;
          bit_q <= {BIT_W{1'b0}};
        end
        ST_GAIN_SHIFT: begin
          if (tick_s) begin
            if (!sck_q) begin
              sck_q  <= 1'b1;
              bit_q  <= bit_q + ONE;
              echo_q <= {echo_q[GAIN_W-2:0], bus.amp_dout};
            end else begin
              sck_q <= 1'b0;
              if (bit_q == GAIN_LAST) begin
                state_q <= ST_GAIN_END;
                cs_q    <= 1'b1;
                mosi_q  <= 1'b0;
                bit_q   <= {BIT_W{1'b0}};
              end else begin
                gsh_q  <= gsh_q << 1;
                mosi_q <= gsh_q[GAIN_W-2];
              end
            end
          end
        end
        ST_GAIN_END: begin
          if (tick_s) begin
            if (bit_q == ONE) begin
              bit_q <= {BIT_W{1'b0}};
              if (bus.enable) begin
                state_q <= ST_CONV;
                conv_q  <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + ONE;
            end
          end
        end
        ST_CONV: begin
          if (tick_s) begin
            if (bit_q == ONE) begin
              state_q <= ST_READ;
              conv_q  <= 1'b0;
              bit_q   <= {BIT_W{1'b0}};
            end else begin
              bit_q <= bit_q + ONE;
            end
          end
        end
        ST_READ: begin
          if (tick_s) begin
            if (!sck_q) begin
              sck_q <= 1'b1;
              bit_q <= bit_q + ONE;
              if ((bit_q >= A_FIRST) && (bit_q <= A_LAST)) begin
                sa_q <= {sa_q[DATA_W-2:0], bus.adc_dout};
              end
              if ((bit_q >= B_FIRST) && (bit_q <= B_LAST)) begin
                sb_q <= {sb_q[DATA_W-2:0], bus.adc_dout};
              end
            end else begin
              sck_q <= 1'b0;
              if (bit_q == READ_LAST) begin
                cha_q   <= sa_q;
                chb_q   <= sb_q;
                valid_q <= 1'b1;
                bit_q   <= {BIT_W{1'b0}};
                state_q <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (tick_s) begin
            bit_q <= bit_q + ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sck_q   <= 1'b0;
          cs_q    <= 1'b1;
          conv_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
      // Launch overrides the per-state updates above.
      if (launch_s) begin
        bit_q <= {BIT_W{1'b0}};
        sck_q <= 1'b0;
        if (pend_s) begin
          state_q <= ST_GAIN_SHIFT;
          pend_q  <= 1'b0;
          gsh_q   <= word_s;
          mosi_q  <= word_s[GAIN_W-1];
          cs_q    <= 1'b0;
          busy_q  <= 1'b1;
        end else if (bus.enable) begin
          state_q <= ST_CONV;
          conv_q  <= 1'b1;
          busy_q  <= 1'b1;
        end else begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.spi_sck      = sck_q;
  assign bus.spi_mosi     = mosi_q;
  assign bus.amp_cs       = cs_q;
  assign bus.ad_conv      = conv_q;
  assign bus.ch_a         = cha_q;
  assign bus.ch_b         = chb_q;
  assign bus.sample_valid = valid_q;
  assign bus.gain_echo    = echo_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_adc_dual_capture.sv
`timescale 1ns/1ps
// Directed bench for adc_dual_capture with a shift-register amplifier model
// (echoes its previous contents) and an ADC model that shifts a 34-bit frame
// out on SCK falling edges after each conversion strobe.
module tb_adc_dual_capture;
  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 14;
  localparam int GAIN_W  = 8;
  localparam int GAP     = 3;
  localparam int TIMEOUT = 2000;
  // (1 conv + 34 read + 3 gap) SCK periods * 4 clk * 10 ns
  localparam time PERIOD_NS = 1520;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  adc_dual_capture_if #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) bus ();

  adc_dual_capture #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .GAIN_W(GAIN_W), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]          amp_sr = 8'hFF;
  logic [2*DATA_W+5:0] adc_sr = '0;
  logic [DATA_W-1:0]   a_val = '0;
  logic [DATA_W-1:0]   b_val = '0;
  logic [7:0]          mosi_sh = 8'h00;
  logic sck_prev = 1'b0, cs_prev = 1'b1, conv_prev = 1'b0;
  int   sck_rises = 0, amp_pulses = 0, valid_cnt = 0, conv_clks = 0;
  time  t_valid = 0, t_valid_prev = 0, t_cs_fall = 0, t_conv_rise = 0;

  assign bus.amp_dout = amp_sr[7];
  assign bus.adc_dout = adc_sr[2*DATA_W+5];

  // Peripheral models and event monitors, sampled away from the active edge.
  always @(negedge clk) begin
    sck_prev  <= bus.spi_sck;
    cs_prev   <= bus.amp_cs;
    conv_prev <= bus.ad_conv;
    if (bus.spi_sck && !sck_prev) begin
      sck_rises <= sck_rises + 1;
      if (!bus.amp_cs) begin
        amp_pulses <= amp_pulses + 1;
        mosi_sh    <= {mosi_sh[6:0], bus.spi_mosi};
        amp_sr     <= {amp_sr[6:0], bus.spi_mosi};
      end
    end
    if (bus.ad_conv) adc_sr <= {2'b10, a_val, 2'b01, b_val, 2'b11};
    else if (!bus.spi_sck && sck_prev) adc_sr <= adc_sr << 1;
    if (bus.ad_conv) conv_clks <= conv_clks + 1;
    if (bus.ad_conv && !conv_prev) t_conv_rise <= $time;
    if (!bus.amp_cs && cs_prev) t_cs_fall <= $time;
    if (bus.sample_valid) begin
      valid_cnt    <= valid_cnt + 1;
      t_valid_prev <= t_valid;
      t_valid      <= $time;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      if (!bus.busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      if (bus.sample_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_conv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      if (bus.ad_conv) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rises(input int n, output bit ok);
    int base;
    base = sck_rises;
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      if (sck_rises - base >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_gain(input logic [7:0] w);
    bus.gain_word = w;
    bus.gain_req  = 1'b1;
    step();
    bus.gain_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++; if ({bus.spi_sck, bus.spi_mosi, bus.amp_cs, bus.ad_conv, bus.sample_valid, bus.busy} !== 6'b001000) begin n_bad++; $display("FAIL reset_pins: got %b want 001000", {bus.spi_sck, bus.spi_mosi, bus.amp_cs, bus.ad_conv, bus.sample_valid, bus.busy}); end
    n_cmp++; if ({bus.ch_a, bus.ch_b} !== 28'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {bus.ch_a, bus.ch_b}); end
    n_cmp++; if (bus.gain_echo !== 8'hFF) begin n_bad++; $display("FAIL reset_echo: got %h want ff", bus.gain_echo); end
    rst = 1'b0;
    repeat (5) step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_gain_load();
    bit ok;
    int bp, bc;
    bp = amp_pulses; bc = conv_clks;
    pulse_gain(8'h11);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL gain_idle: got timeout want idle"); end
    n_cmp++; if (amp_pulses - bp != 8) begin n_bad++; $display("FAIL gain_pulses: got %0d want 8", amp_pulses - bp); end
    n_cmp++; if (mosi_sh !== 8'h11) begin n_bad++; $display("FAIL gain_mosi: got %h want 11", mosi_sh); end
    n_cmp++; if (bus.gain_echo !== 8'hFF) begin n_bad++; $display("FAIL gain_echo: got %h want ff", bus.gain_echo); end
    n_cmp++; if (conv_clks - bc != 0) begin n_bad++; $display("FAIL gain_no_conv: got %0d want 0", conv_clks - bc); end
    n_cmp++; if ({bus.amp_cs, bus.spi_sck} !== 2'b10) begin n_bad++; $display("FAIL gain_end_pins: got %b want 10", {bus.amp_cs, bus.spi_sck}); end
  endtask

  task automatic test_single_frame();
    bit ok;
    int bv, bs, bc;
    a_val = 14'h1FFF; b_val = 14'h2000;
    bv = valid_cnt; bs = sck_rises; bc = conv_clks;
    bus.enable = 1'b1;
    wait_conv(ok);
    bus.enable = 1'b0;
    wait_valid(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL frame_valid: got timeout want pulse"); end
    n_cmp++; if (bus.ch_a !== 14'h1FFF) begin n_bad++; $display("FAIL frame_ch_a: got %h want 1fff", bus.ch_a); end
    n_cmp++; if (bus.ch_b !== 14'h2000) begin n_bad++; $display("FAIL frame_ch_b: got %h want 2000", bus.ch_b); end
    n_cmp++; if (conv_clks - bc != 4) begin n_bad++; $display("FAIL frame_conv_len: got %0d want 4", conv_clks - bc); end
    n_cmp++; if (sck_rises - bs != 34) begin n_bad++; $display("FAIL frame_pulses: got %0d want 34", sck_rises - bs); end
    wait_idle(ok);
    n_cmp++; if (valid_cnt - bv != 1) begin n_bad++; $display("FAIL frame_valid_cnt: got %0d want 1", valid_cnt - bv); end
    n_cmp++; if (bus.spi_sck !== 1'b0) begin n_bad++; $display("FAIL frame_sck_idle: got %b want 0", bus.spi_sck); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int bv;
    a_val = 14'h0ABC; b_val = 14'h3F01;
    bv = valid_cnt;
    bus.enable = 1'b1;
    wait_valid(ok1);
    wait_valid(ok2);
    bus.enable = 1'b0;
    n_cmp++; if (!(ok1 && ok2)) begin n_bad++; $display("FAIL b2b_valid: got timeout want two pulses"); end
    n_cmp++; if (t_valid - t_valid_prev != PERIOD_NS) begin n_bad++; $display("FAIL b2b_period: got %0t want %0t", t_valid - t_valid_prev, PERIOD_NS); end
    n_cmp++; if ({bus.ch_a, bus.ch_b} !== {14'h0ABC, 14'h3F01}) begin n_bad++; $display("FAIL b2b_data: got %h %h want 0abc 3f01", bus.ch_a, bus.ch_b); end
    wait_idle(ok1);
    n_cmp++; if (valid_cnt - bv != 2) begin n_bad++; $display("FAIL b2b_valid_cnt: got %0d want 2", valid_cnt - bv); end
  endtask

  task automatic test_gain_during_read();
    bit ok;
    time t0;
    a_val = 14'h2AAA; b_val = 14'h1555;
    bus.enable = 1'b1;
    wait_conv(ok);
    wait_rises(10, ok);
    pulse_gain(8'hA5);
    wait_valid(ok);
    n_cmp++; if ({bus.ch_a, bus.ch_b} !== {14'h2AAA, 14'h1555}) begin n_bad++; $display("FAIL gread_frame_n: got %h %h want 2aaa 1555", bus.ch_a, bus.ch_b); end
    t0 = $time;
    a_val = 14'h0123; b_val = 14'h3210;
    wait_conv(ok);
    bus.enable = 1'b0;
    n_cmp++; if (!(t_cs_fall > t0 && t_cs_fall < t_conv_rise)) begin n_bad++; $display("FAIL gread_order: got cs_fall %0t conv %0t want cs first after %0t", t_cs_fall, t_conv_rise, t0); end
    n_cmp++; if (mosi_sh !== 8'hA5) begin n_bad++; $display("FAIL gread_mosi: got %h want a5", mosi_sh); end
    n_cmp++; if (bus.gain_echo !== 8'h11) begin n_bad++; $display("FAIL gread_echo: got %h want 11", bus.gain_echo); end
    wait_valid(ok);
    n_cmp++; if ({bus.ch_a, bus.ch_b} !== {14'h0123, 14'h3210}) begin n_bad++; $display("FAIL gread_frame_n1: got %h %h want 0123 3210", bus.ch_a, bus.ch_b); end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bv;
    a_val = 14'h1234; b_val = 14'h0F0F;
    bus.enable = 1'b1;
    wait_conv(ok);
    wait_rises(21, ok);
    bv = valid_cnt;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.spi_sck, bus.spi_mosi, bus.amp_cs, bus.ad_conv, bus.sample_valid, bus.busy} !== 6'b001000) begin n_bad++; $display("FAIL rstmid_pins: got %b want 001000", {bus.spi_sck, bus.spi_mosi, bus.amp_cs, bus.ad_conv, bus.sample_valid, bus.busy}); end
    n_cmp++; if ({bus.ch_a, bus.ch_b, bus.gain_echo} !== {28'h0, 8'hFF}) begin n_bad++; $display("FAIL rstmid_data: got %h want 0000000ff", {bus.ch_a, bus.ch_b, bus.gain_echo}); end
    bus.enable = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (200) step();
    n_cmp++; if (valid_cnt - bv != 0) begin n_bad++; $display("FAIL rstmid_no_valid: got %0d want 0", valid_cnt - bv); end
    n_cmp++; if ({bus.busy, bus.spi_sck} !== 2'b00) begin n_bad++; $display("FAIL rstmid_idle: got %b want 00", {bus.busy, bus.spi_sck}); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int bv;
    a_val = 14'h3FFF; b_val = 14'h0001;
    bv = valid_cnt;
    bus.enable = 1'b1;
    wait_conv(ok);
    wait_rises(6, ok);
    bus.enable = 1'b0;
    wait_valid(ok);
    n_cmp++; if ({bus.ch_a, bus.ch_b} !== {14'h3FFF, 14'h0001}) begin n_bad++; $display("FAIL endrop_data: got %h %h want 3fff 0001", bus.ch_a, bus.ch_b); end
    wait_idle(ok);
    repeat (50) step();
    n_cmp++; if (valid_cnt - bv != 1) begin n_bad++; $display("FAIL endrop_valid_cnt: got %0d want 1", valid_cnt - bv); end
    n_cmp++; if ({bus.busy, bus.spi_sck, bus.amp_cs} !== 3'b001) begin n_bad++; $display("FAIL endrop_idle: got %b want 001", {bus.busy, bus.spi_sck, bus.amp_cs}); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    time t0;
    a_val = 14'h2001; b_val = 14'h1FFE;
    t0 = $time;
    bus.gain_word = 8'h3C;
    bus.gain_req  = 1'b1;
    bus.enable    = 1'b1;
    step();
    bus.gain_req  = 1'b0;
    wait_conv(ok);
    bus.enable    = 1'b0;
    n_cmp++; if (!(t_cs_fall > t0 && t_cs_fall < t_conv_rise)) begin n_bad++; $display("FAIL simul_order: got cs_fall %0t conv %0t want cs first after %0t", t_cs_fall, t_conv_rise, t0); end
    n_cmp++; if ({mosi_sh, bus.gain_echo} !== {8'h3C, 8'hA5}) begin n_bad++; $display("FAIL simul_gain: got %h want 3ca5", {mosi_sh, bus.gain_echo}); end
    wait_valid(ok);
    n_cmp++; if ({bus.ch_a, bus.ch_b} !== {14'h2001, 14'h1FFE}) begin n_bad++; $display("FAIL simul_data: got %h %h want 2001 1ffe", bus.ch_a, bus.ch_b); end
    wait_idle(ok);
  endtask

  initial begin
    rst           = 1'b0;
    bus.enable    = 1'b0;
    bus.gain_req  = 1'b0;
    bus.gain_word = 8'h00;
    #1;
    test_reset();
    test_gain_load();
    test_single_frame();
    test_back_to_back();
    test_gain_during_read();
    test_reset_mid();
    test_enable_drop();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
